// File: rtl/inst_fetch_if.sv
// inst_fetch_if: responder side of the PC fetch interface.
// Takes pc/ce from the PC register, fetches the instruction word from
// instruction memory over a req/ack port and returns it on inst.
// The last fetched word is held, and stallreq is raised while a fetch
// is outstanding.
// Optional feature macro: IF_TIMEOUT_EN. When it is defined, a request
// that gets no ack within TIMEOUT_CYC cycles is aborted and flagged on
// if_err.
//
// Handshake: rom_req rises on entry to REQ. rom_addr is held stable
// while rom_req=1. rom_ack is looked at only while rom_req=1, and the
// transfer completes in the cycle where rom_req and rom_ack are both 1.
// On that cycle rom_rdata is captured.
module inst_fetch_if #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              stallreq,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic              rom_ack,
    output logic              if_err,
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              hold_vld;
    logic              drop;
    logic              hit;
    logic              miss_start;
    logic              ack;
    logic              tmo_fire;
    logic              done;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    assign hit        = hold_vld && (pc == hold_addr);
    assign miss_start = ce && !hit && !flush;
    assign ack        = (state == REQ) && rom_ack;
    assign done       = ack || tmo_fire;

`ifdef IF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             if_err_q;

    assign tmo_fire = (state == REQ) && !rom_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Count REQ cycles without ack; restart from zero on each new request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE && miss_start) begin
            tmo_cnt <= '0;
        end else if (state == REQ && !rom_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_err_q <= 1'b0;
        end else if (tmo_fire) begin
            if_err_q <= 1'b1;
        end
    end

    assign if_err = rst && if_err_q;
`else
    assign tmo_fire = 1'b0;
    assign if_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start a fetch on a miss, return to IDLE on ack or abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss_start) state_nxt = REQ;
            REQ:  if (done)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request address and held word; pc is ignored while a request is open
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr  <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            if (state == IDLE && miss_start) begin
                req_addr <= pc;
            end
            if (ack) begin
                hold_data <= rom_rdata;
                hold_addr <= req_addr;
            end else if (tmo_fire) begin
                hold_data <= NOP_WORD;
                hold_addr <= req_addr;
            end
        end
    end

    // Held-word valid bit and the discard marker for flushed requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (flush) begin
                hold_vld <= 1'b0;
            end else if (done) begin
                hold_vld <= !drop;
            end
            if (done) begin
                drop <= 1'b0;
            end else if (state == REQ && flush) begin
                drop <= 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is asserted
    assign inst      = !rst ? '0 : ((ce && hit) ? hold_data : NOP_WORD);
    assign stallreq  = rst && miss_start;
    assign rom_req   = rst && (state == REQ);
    assign rom_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign dbg_state = state;

endmodule

// File: tb/tb_inst_fetch_if.sv
// Testbench for inst_fetch_if: directed scenarios plus a randomized run,
// all checked cycle by cycle against a transaction-level reference model.
module tb_inst_fetch_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TC = 4;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          ce = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] inst;
  logic          stallreq;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata = '0;
  logic          rom_ack = 1'b0;
  logic          if_err;
  logic          dbg_state;

  inst_fetch_if #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TC), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .inst(inst), .stallreq(stallreq), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .rom_ack(rom_ack), .if_err(if_err), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // reference model: one held entry plus a queue of outstanding fetch pcs
  bit          m_vld;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit          m_drop;
  bit          m_err;
  int          m_wait;
  logic [AW-1:0] exp_q[$];

  // memory responder knobs
  int          ack_lat = 0;
  bit          no_ack = 0;
  bit          fix_rdata = 0;
  logic [DW-1:0] fix_val = '0;

  // last observed values
  bit          obs_stall;
  bit          obs_req;
  logic [DW-1:0] obs_inst;
  logic [AW-1:0] obs_addr;

  task automatic model_reset();
    m_vld = 0; m_drop = 0; m_err = 0; m_wait = 0;
    m_addr = '0; m_data = '0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; flush = 1'b0; rom_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // driver + checker for one clock cycle
  task automatic cycle(input bit c, input logic [AW-1:0] p, input bit f);
    bit busy, hit, ack, tmo, e_stall;
    logic [DW-1:0] e_inst;
    logic [AW-1:0] e_raddr;
    @(negedge clk);
    busy = (exp_q.size() != 0);
    ce = c; pc = p; flush = f;
    ack = busy && !no_ack && (m_wait >= ack_lat);
    rom_ack = busy ? ack : 1'($urandom_range(0, 1));
    rom_rdata = (ack && fix_rdata) ? fix_val : $urandom;
    #1;
    hit = m_vld && (p == m_addr);
    e_inst = (c && hit) ? m_data : NOP;
    e_stall = c && !hit && !f;
    checks++;
    if (inst !== e_inst) begin
      errors++; $display("FAIL inst: got %h want %h (pc %h)", inst, e_inst, p);
    end
    checks++;
    if (stallreq !== e_stall) begin
      errors++; $display("FAIL stallreq: got %b want %b (pc %h)", stallreq, e_stall, p);
    end
    checks++;
    if (rom_req !== busy) begin
      errors++; $display("FAIL rom_req: got %b want %b", rom_req, busy);
    end
    checks++;
    if (if_err !== m_err) begin
      errors++; $display("FAIL if_err: got %b want %b", if_err, m_err);
    end
    if (busy) begin
      e_raddr = {exp_q[0][AW-1:2], 2'b00};
      checks++;
      if (rom_addr !== e_raddr) begin
        errors++; $display("FAIL rom_addr: got %h want %h", rom_addr, e_raddr);
      end
    end
    obs_stall = stallreq; obs_req = rom_req; obs_inst = inst; obs_addr = rom_addr;
    // model update for the coming edge
`ifdef IF_TIMEOUT_EN
    tmo = busy && !ack && (m_wait == TC - 1);
`else
    tmo = 0;
`endif
    if (busy) begin
      if (ack || tmo) begin
        m_data = ack ? rom_rdata : NOP;
        m_addr = exp_q.pop_front();
        m_vld = !m_drop && !f;
        m_drop = 0;
        if (tmo) m_err = 1;
        m_wait = 0;
      end else begin
        m_wait++;
        if (f) begin m_drop = 1; m_vld = 0; end
      end
    end else begin
      if (f) m_vld = 0;
      if (e_stall) begin exp_q.push_back(p); m_wait = 0; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; pc = 32'h0; rom_ack = 1'b1;
    #1;
    checks++; if (inst !== '0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stallreq); end
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", rom_req); end
    checks++; if (if_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", if_err); end
    apply_reset();
  endtask

  task automatic test_first_fetch();
    int n;
    apply_reset();
    ack_lat = 1; no_ack = 0; fix_rdata = 1; fix_val = 32'h3401_1100;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 32'h0, 0);
      if (obs_stall) n++; else break;
    end
    fix_rdata = 0;
    checks++; if (n != 3) begin errors++; $display("FAIL first_stalls: got %0d want 3", n); end
    checks++;
    if (obs_inst !== 32'h3401_1100) begin
      errors++; $display("FAIL first_inst: got %h want 34011100", obs_inst);
    end
  endtask

  task automatic test_sequential();
    int n;
    logic [AW-1:0] p;
    apply_reset();
    ack_lat = 0; no_ack = 0;
    for (int k = 0; k < 3; k++) begin
      p = AW'(k * 4);
      n = 0;
      for (int i = 0; i < 10; i++) begin
        cycle(1, p, 0);
        if (obs_stall) n++; else break;
      end
      checks++; if (n != 2) begin errors++; $display("FAIL seq_stalls pc %h: got %0d want 2", p, n); end
      cycle(1, p, 0);
      cycle(1, p, 0);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    ack_lat = 2; no_ack = 0;
    cycle(1, 32'h10, 0);
    cycle(1, 32'h10, 1);
    cycle(1, 32'h10, 0);
    cycle(1, 32'h10, 0);
    cycle(0, 32'h10, 0);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", obs_req); end
    cycle(1, 32'h10, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL flush_refetch_stall: got %b want 1", obs_stall); end
    cycle(1, 32'h10, 0);
    checks++; if (obs_req !== 1'b1) begin errors++; $display("FAIL flush_refetch_req: got %b want 1", obs_req); end
    for (int i = 0; i < 4; i++) cycle(1, 32'h10, 0);
  endtask

  task automatic test_reset_mid_req();
    apply_reset();
    no_ack = 1;
    cycle(1, 32'h40, 0);
    cycle(1, 32'h40, 0);
    @(negedge clk);
    rst = 1'b0; rom_ack = 1'b0;
    #1;
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b want 0", rom_req); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b want 0", stallreq); end
    checks++; if (inst !== '0) begin errors++; $display("FAIL midreset_inst: got %h want 0", inst); end
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    no_ack = 0; ack_lat = 0;
    cycle(0, 32'h40, 0);
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL midreset_state: got %b want 0", dbg_state); end
    for (int i = 0; i < 4; i++) cycle(1, 32'h40, 0);
  endtask

  task automatic test_misaligned();
    bit seen;
    logic [AW-1:0] a;
    apply_reset();
    ack_lat = 0; no_ack = 0;
    seen = 0; a = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h6, 0);
      if (obs_req && !seen) begin seen = 1; a = obs_addr; end
      if (!obs_stall) break;
    end
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL misaligned_addr: got %h want 00000004", a); end
    cycle(1, 32'h4, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL misaligned_miss: got %b want 1", obs_stall); end
    for (int i = 0; i < 4; i++) cycle(1, 32'h4, 0);
  endtask

`ifdef IF_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    apply_reset();
    no_ack = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 32'h20, 0);
      if (obs_req) n++; else if (n > 0) break;
    end
    checks++; if (n != TC) begin errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", n, TC); end
    checks++; if (obs_inst !== NOP) begin errors++; $display("FAIL tmo_inst: got %h want %h", obs_inst, NOP); end
    checks++; if (if_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", if_err); end
    no_ack = 0;
    for (int i = 0; i < 4; i++) cycle(1, 32'h24, 0);
    checks++; if (if_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b want 1", if_err); end
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] p;
    bit c, f;
    apply_reset();
    no_ack = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) ack_lat = $urandom_range(0, 3);
      p = AW'($urandom_range(0, 7) * 2);
      c = ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 24) == 0);
      cycle(c, p, f);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_sequential();
    test_flush();
    test_reset_mid_req();
    test_misaligned();
`ifdef IF_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
